// File: rtl/nastilite_modport.sv
// NASTI-Lite slave register bank: NUM_REGS byte-strobed registers behind independent AW/W/B and AR/R channels.
// Optional macro NASTILITE_USER_ECHO_EN: echo the captured aw_user/ar_user on b_user/r_user (tied to 0 otherwise).
module nastilite_modport #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 1,
   parameter int NUM_REGS   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic [2:0]              aw_prot,
   input  logic [3:0]              aw_qos,
   input  logic [3:0]              aw_region,
   input  logic [USER_WIDTH-1:0]   aw_user,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic [USER_WIDTH-1:0]   w_user,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [1:0]              b_resp,
   output logic [USER_WIDTH-1:0]   b_user,
   output logic                    b_valid,
   input  logic                    b_ready,
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic [2:0]              ar_prot,
   input  logic [3:0]              ar_qos,
   input  logic [3:0]              ar_region,
   input  logic [USER_WIDTH-1:0]   ar_user,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic [USER_WIDTH-1:0]   r_user,
   output logic                    r_valid,
   input  logic                    r_ready
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int LSB        = $clog2(STRB_WIDTH);
   localparam int IDX_WIDTH  = ADDR_WIDTH - LSB;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
      $fatal(1, "nastilite_modport: DATA_WIDTH must be 32 or 64");
   end
   if (NUM_REGS > (1 << IDX_WIDTH)) begin : g_bad_num_regs
      $fatal(1, "nastilite_modport: NUM_REGS exceeds the decodable word range");
   end

   function automatic logic idx_in_range(input logic [IDX_WIDTH-1:0] idx);
      return (32'(idx) < 32'(NUM_REGS));
   endfunction

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [IDX_WIDTH-1:0]  aw_idx_q, aw_idx_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
   logic                  b_valid_q, b_valid_d, r_valid_q, r_valid_d;
   logic [1:0]            b_resp_q, b_resp_d, r_resp_q, r_resp_d;
   logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
   logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
   logic [IDX_WIDTH-1:0]  ar_idx_s;
   logic [DATA_WIDTH-1:0] rd_data_s;
   logic                  unused_s;

   assign aw_ready = ~aw_held_q;
   assign w_ready  = ~w_held_q;
   assign ar_ready = ~r_valid_q;
   assign b_valid  = b_valid_q;
   assign b_resp   = b_resp_q;
   assign r_valid  = r_valid_q;
   assign r_data   = r_data_q;
   assign r_resp   = r_resp_q;

   assign aw_hs_s  = aw_valid & ~aw_held_q;
   assign w_hs_s   = w_valid & ~w_held_q;
   assign ar_hs_s  = ar_valid & ~r_valid_q;
   // A write commits only once both halves are held and the previous B has been consumed.
   assign commit_s = aw_held_q & w_held_q & ~b_valid_q;
   assign ar_idx_s = ar_addr[ADDR_WIDTH-1:LSB];

   // Read mux over implemented registers; out-of-range indices fall through to zero.
   always_comb begin
      rd_data_s = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         rd_data_s = rd_data_s | ((ar_idx_s == IDX_WIDTH'(i)) ? regs_q[i] : '0);
      end
   end

   // Byte-lane merge of the held write into the addressed register at commit.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            regs_d[i][8*b +: 8] = (commit_s && (aw_idx_q == IDX_WIDTH'(i)) && w_strb_q[b])
                                  ? w_data_q[8*b +: 8] : regs_q[i][8*b +: 8];
         end
      end
   end

   // Channel holds and response next-state.
   always_comb begin
      aw_held_d = aw_hs_s | (aw_held_q & ~commit_s);
      aw_idx_d  = aw_hs_s ? aw_addr[ADDR_WIDTH-1:LSB] : aw_idx_q;
      w_held_d  = w_hs_s | (w_held_q & ~commit_s);
      w_data_d  = w_hs_s ? w_data : w_data_q;
      w_strb_d  = w_hs_s ? w_strb : w_strb_q;
      b_valid_d = commit_s | (b_valid_q & ~b_ready);
      b_resp_d  = commit_s ? (idx_in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR) : b_resp_q;
      r_valid_d = ar_hs_s | (r_valid_q & ~r_ready);
      r_data_d  = ar_hs_s ? rd_data_s : r_data_q;
      r_resp_d  = ar_hs_s ? (idx_in_range(ar_idx_s) ? RESP_OKAY : RESP_SLVERR) : r_resp_q;
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_valid_q <= 1'b0;
         b_resp_q  <= 2'b00;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= 2'b00;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         b_valid_q <= b_valid_d;
         b_resp_q  <= b_resp_d;
         r_valid_q <= r_valid_d;
         r_data_q  <= r_data_d;
         r_resp_q  <= r_resp_d;
      end
   end

`ifdef NASTILITE_USER_ECHO_EN
   logic [USER_WIDTH-1:0] aw_user_q, aw_user_d, b_user_q, b_user_d, r_user_q, r_user_d;

   // User sideband travels with its request and returns with the matching response.
   always_comb begin
      aw_user_d = aw_hs_s ? aw_user : aw_user_q;
      b_user_d  = commit_s ? aw_user_q : b_user_q;
      r_user_d  = ar_hs_s ? ar_user : r_user_q;
   end

   // User sideband registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_user_q <= '0;
         b_user_q  <= '0;
         r_user_q  <= '0;
      end else begin
         aw_user_q <= aw_user_d;
         b_user_q  <= b_user_d;
         r_user_q  <= r_user_d;
      end
   end

   assign b_user   = b_user_q;
   assign r_user   = r_user_q;
   assign unused_s = ^{aw_prot, aw_qos, aw_region, w_user, ar_prot, ar_qos, ar_region,
                       aw_addr[LSB-1:0], ar_addr[LSB-1:0]};
`else
   assign b_user   = '0;
   assign r_user   = '0;
   assign unused_s = ^{aw_prot, aw_qos, aw_region, w_user, ar_prot, ar_qos, ar_region,
                       aw_addr[LSB-1:0], ar_addr[LSB-1:0], aw_user, ar_user};
`endif

endmodule

// File: tb/tb_nastilite_modport.sv
// Directed bench for nastilite_modport (NUM_REGS=3) with a transaction-level reference model checked every cycle.
module tb_nastilite_modport;
   localparam int NREGS = 3;
`ifdef NASTILITE_USER_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  aw_addr = '0, ar_addr = '0;
   logic [2:0]  aw_prot = 3'd5, ar_prot = 3'd2;
   logic [3:0]  aw_qos = 4'hA, aw_region = 4'h3, ar_qos = 4'h6, ar_region = 4'h9;
   logic [0:0]  aw_user = '0, w_user = '0, ar_user = '0, b_user, r_user;
   logic        aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0, b_ready = 1'b0, r_ready = 1'b0;
   logic        aw_ready, w_ready, ar_ready, b_valid, r_valid;
   logic [63:0] w_data = '0, r_data;
   logic [7:0]  w_strb = '0;
   logic [1:0]  b_resp, r_resp;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   nastilite_modport #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .USER_WIDTH(1), .NUM_REGS(NREGS)) dut (
      .clk(clk), .rst(rst),
      .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_qos(aw_qos), .aw_region(aw_region),
      .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_user(w_user), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
      .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_qos(ar_qos), .ar_region(ar_region),
      .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_user(r_user), .r_valid(r_valid), .r_ready(r_ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: pending write halves, outstanding responses, register contents.
   bit          m_aw_pend, m_w_pend, m_b_valid, m_r_valid;
   int          m_aw_word;
   bit          m_aw_user, m_b_user, m_r_user;
   logic [63:0] m_w_data, m_r_data;
   logic [7:0]  m_w_strb;
   logic [1:0]  m_b_resp, m_r_resp;
   logic [63:0] m_regs [4];

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
      logic [63:0] res;
      res = old;
      for (int k = 0; k < 8; k++) if (s[k]) res[8*k +: 8] = d[8*k +: 8];
      return res;
   endfunction

   initial forever begin
      bit aw_acc, w_acc, ar_acc, wr_done, b_taken, r_taken;
      int rd_word;
      @(posedge clk);
      if (rst) begin
         m_aw_pend = 0; m_w_pend = 0; m_b_valid = 0; m_r_valid = 0;
         m_b_resp = 2'b00; m_r_resp = 2'b00; m_r_data = '0; m_b_user = 0; m_r_user = 0;
         for (int k = 0; k < 4; k++) m_regs[k] = '0;
      end else begin
         aw_acc  = aw_valid && !m_aw_pend;
         w_acc   = w_valid && !m_w_pend;
         ar_acc  = ar_valid && !m_r_valid;
         wr_done = m_aw_pend && m_w_pend && !m_b_valid;
         b_taken = m_b_valid && b_ready;
         r_taken = m_r_valid && r_ready;
         if (ar_acc) begin
            rd_word   = int'(ar_addr) / 8;
            m_r_data  = (rd_word < NREGS) ? m_regs[rd_word] : 64'h0;
            m_r_resp  = (rd_word < NREGS) ? 2'b00 : 2'b10;
            m_r_user  = ECHO ? ar_user[0] : 1'b0;
            m_r_valid = 1;
         end else if (r_taken) m_r_valid = 0;
         if (wr_done) begin
            if (m_aw_word < NREGS) m_regs[m_aw_word] = merge(m_regs[m_aw_word], m_w_data, m_w_strb);
            m_b_resp  = (m_aw_word < NREGS) ? 2'b00 : 2'b10;
            m_b_user  = ECHO ? m_aw_user : 1'b0;
            m_b_valid = 1;
            m_aw_pend = 0;
            m_w_pend  = 0;
         end else if (b_taken) m_b_valid = 0;
         if (aw_acc) begin
            m_aw_pend = 1; m_aw_word = int'(aw_addr) / 8; m_aw_user = aw_user[0];
         end
         if (w_acc) begin
            m_w_pend = 1; m_w_data = w_data; m_w_strb = w_strb;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("aw_ready", aw_ready, !m_aw_pend);
         check("w_ready",  w_ready,  !m_w_pend);
         check("ar_ready", ar_ready, !m_r_valid);
         check("b_valid",  b_valid,  m_b_valid);
         check("r_valid",  r_valid,  m_r_valid);
         if (m_b_valid) begin
            check("b_resp", b_resp, m_b_resp);
            check("b_user", b_user, m_b_user);
         end
         if (m_r_valid) begin
            check("r_data", r_data, m_r_data);
            check("r_resp", r_resp, m_r_resp);
            check("r_user", r_user, m_r_user);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_chk(input logic [4:0] a, input logic [63:0] d, input logic [7:0] s,
                            input bit u, input logic [1:0] exp_resp);
      aw_valid = 1'b1; aw_addr = a; aw_user = u;
      w_valid  = 1'b1; w_data = d; w_strb = s;
      tick();
      aw_valid = 1'b0; w_valid = 1'b0; aw_user = '0;
      check("wr_holds_aw_ready", aw_ready, 1'b0);
      tick();
      check("wr_b_valid", b_valid, 1'b1);
      check("wr_b_resp", b_resp, exp_resp);
      check("wr_b_user", b_user, ECHO ? u : 1'b0);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      check("wr_b_drop", b_valid, 1'b0);
   endtask

   task automatic read_chk(input logic [4:0] a, input logic [63:0] exp_data, input logic [1:0] exp_resp);
      ar_valid = 1'b1; ar_addr = a;
      tick();
      ar_valid = 1'b0;
      check("rd_r_valid", r_valid, 1'b1);
      check("rd_r_data", r_data, exp_data);
      check("rd_r_resp", r_resp, exp_resp);
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_aw_ready", aw_ready, 1'b1);
      check("rst_w_ready", w_ready, 1'b1);
      check("rst_ar_ready", ar_ready, 1'b1);
      check("rst_b_valid", b_valid, 1'b0);
      check("rst_r_valid", r_valid, 1'b0);

      // Full write then read back.
      write_chk(5'h08, 64'h1122334455667788, 8'hFF, 1'b0, 2'b00);
      read_chk(5'h08, 64'h1122334455667788, 2'b00);

      // Low-half strobe only.
      write_chk(5'h08, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b0, 2'b00);
      read_chk(5'h08, 64'h11223344FFFFFFFF, 2'b00);

      // W three cycles ahead of AW, B back-pressured, second write queued behind it.
      w_valid = 1'b1; w_data = 64'hA5A5000000005A5A; w_strb = 8'hFF;
      tick();
      w_valid = 1'b0;
      check("wfirst_w_ready", w_ready, 1'b0);
      check("wfirst_aw_ready", aw_ready, 1'b1);
      tick(); tick();
      check("wfirst_no_b", b_valid, 1'b0);
      aw_valid = 1'b1; aw_addr = 5'h10;
      tick();
      aw_valid = 1'b0;
      check("held_aw_ready", aw_ready, 1'b0);
      check("held_w_ready", w_ready, 1'b0);
      tick();
      check("late_b_valid", b_valid, 1'b1);
      aw_valid = 1'b1; aw_addr = 5'h00; w_valid = 1'b1; w_data = 64'h00000000DEADBEEF; w_strb = 8'h0F;
      tick();
      aw_valid = 1'b0; w_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("bpress_b_valid", b_valid, 1'b1);
         check("bpress_aw_ready", aw_ready, 1'b0);
         check("bpress_w_ready", w_ready, 1'b0);
         tick();
      end
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      check("bpress_drop", b_valid, 1'b0);
      tick();
      check("queued_b_valid", b_valid, 1'b1);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      read_chk(5'h10, 64'hA5A5000000005A5A, 2'b00);
      read_chk(5'h00, 64'h00000000DEADBEEF, 2'b00);

      // Out of range index 3.
      write_chk(5'h18, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 2'b10);
      read_chk(5'h18, 64'h0, 2'b10);
      read_chk(5'h1F, 64'h0, 2'b10);
      read_chk(5'h00, 64'h00000000DEADBEEF, 2'b00);
      read_chk(5'h0C, 64'h11223344FFFFFFFF, 2'b00);
      read_chk(5'h10, 64'hA5A5000000005A5A, 2'b00);

      // Read and commit on the same register at the same edge.
      aw_valid = 1'b1; aw_addr = 5'h10; w_valid = 1'b1; w_data = 64'h0123456789ABCDEF; w_strb = 8'hFF;
      tick();
      aw_valid = 1'b0; w_valid = 1'b0;
      ar_valid = 1'b1; ar_addr = 5'h10;
      tick();
      ar_valid = 1'b0;
      check("collide_old_data", r_data, 64'hA5A5000000005A5A);
      check("collide_b_valid", b_valid, 1'b1);
      r_ready = 1'b1; b_ready = 1'b1;
      tick();
      r_ready = 1'b0; b_ready = 1'b0;
      read_chk(5'h10, 64'h0123456789ABCDEF, 2'b00);

      // User echo and R back-pressure with a competing AR.
      write_chk(5'h00, 64'h0, 8'h00, 1'b1, 2'b00);
      ar_valid = 1'b1; ar_addr = 5'h08; ar_user = 1'b1;
      tick();
      ar_addr = 5'h00; ar_user = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("rpress_r_valid", r_valid, 1'b1);
         check("rpress_ar_ready", ar_ready, 1'b0);
         check("rpress_r_data", r_data, 64'h11223344FFFFFFFF);
         check("rpress_r_user", r_user, ECHO ? 1'b1 : 1'b0);
         tick();
      end
      ar_valid = 1'b0; r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      check("rpress_drop", r_valid, 1'b0);

      // Reset while an AW is held.
      aw_valid = 1'b1; aw_addr = 5'h08;
      tick();
      aw_valid = 1'b0;
      check("midrst_held", aw_ready, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("midrst_aw_ready", aw_ready, 1'b1);
      check("midrst_b_valid", b_valid, 1'b0);
      tick(); tick();
      rst = 1'b0;
      tick();
      read_chk(5'h08, 64'h0, 2'b00);
      read_chk(5'h10, 64'h0, 2'b00);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/nastilite_modport.md
Name: nastilite_modport

Overview:
- NASTI-Lite (AXI4-Lite subset) slave register bank, seen from the slave modport side of the NASTI-Lite interface.
- Holds NUM_REGS data-width registers, writable with byte strobes and readable over independent write and read channels.
- Used as the control/status register block of the DDRx memory controller, attached to the host NASTI-Lite port.

Parameters:
- ADDR_WIDTH, 5, byte-address width of aw_addr/ar_addr.
- DATA_WIDTH, 64, data width. Legal values are 32 or 64; any other value is a fatal elaboration error.
- USER_WIDTH, 1, width of the user fields (minimum 1).
- NUM_REGS, 4, number of implemented registers; must be ≤ 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous active-high reset.
- aw_addr  in  ADDR_WIDTH  write address.
- aw_prot/aw_qos/aw_region  in  3/4/4  accepted and ignored.
- aw_user  in  USER_WIDTH  write user.
- aw_valid  in  1.
- aw_ready  out  1.
- w_data  in  DATA_WIDTH.
- w_strb  in  DATA_WIDTH/8  byte enables.
- w_user  in  USER_WIDTH  ignored.
- w_valid  in  1.
- w_ready  out  1.
- b_resp  out  2.
- b_user  out  USER_WIDTH.
- b_valid  out  1.
- b_ready  in  1.
- ar_addr  in  ADDR_WIDTH.
- ar_prot/ar_qos/ar_region  in  3/4/4  ignored.
- ar_user  in  USER_WIDTH.
- ar_valid  in  1.
- ar_ready  out  1.
- r_data  out  DATA_WIDTH.
- r_resp  out  2.
- r_user  out  USER_WIDTH.
- r_valid  out  1.
- r_ready  in  1.

Behaviour:
- Reset (async, active-high): all registers 0, aw_held/w_held 0, b_valid 0, r_valid 0, r_data 0, b_resp/r_resp 00, user outputs 0. Consequently aw_ready=w_ready=ar_ready=1 after reset.
- Decode: word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-lane bits ignored. Index ≥ NUM_REGS is out of range.
- Write channel:
  - aw_ready = !aw_held; w_ready = !w_held (combinational from state).
  - An AW handshake latches addr/user and sets aw_held. A W handshake latches data/strb and sets w_held. AW and W are independent; either order or the same cycle is legal.
  - On the edge where aw_held & w_held & !b_valid: update the byte lanes with strb=1 if in range, otherwise leave the registers untouched. Set b_valid, set b_resp = 00 (OKAY) or 10 (SLVERR, out of range), and clear both holds.
  - Minimum latency: AW+W accepted at edge N → register updated and b_valid visible after edge N+1.
  - b_valid stays high until a b_ready handshake, then drops. New AW/W may be captured while b_valid=1, but the commit waits until B is consumed.
- Read channel:
  - ar_ready = !r_valid.
  - An AR handshake at edge N loads r_data (register contents before edge N; 0 if out of range), r_resp (00/10) and r_user, and sets r_valid, visible after edge N.
  - r_valid is held until an r_ready handshake. r_data/r_resp are stable while r_valid=1 and !r_ready.
  - Throughput: one read per 2 cycles.
- Simultaneous read and write commit on the same register at the same edge: the read returns the old value.
- Reset mid-transaction aborts everything: pending holds and responses are discarded and registers return to 0.

Optional Feature:
- Macro NASTILITE_USER_ECHO_EN.
- Defined: b_user returns the aw_user captured with the write; r_user returns the ar_user captured at the AR handshake.
- Undefined: b_user and r_user are tied to 0, and aw_user/ar_user are not stored.

Test Plan:
- Reset, then idle → aw_ready=w_ready=ar_ready=1, b_valid=r_valid=0.
- Write addr 0x08, data 0x1122334455667788, strb 0xFF, AW and W in the same cycle; then read 0x08 → b_resp=00 two cycles after the handshake; r_data=0x1122334455667788, r_resp=00.
- Partial strobe: write 0x08 data 0xFFFFFFFFFFFFFFFF strb 0x0F; read 0x08 → 0x11223344FFFFFFFF.
- W three cycles before AW, with b_ready held low 5 cycles → single b_valid pulse held until b_ready; aw_ready/w_ready stay low while held and pending.
- Out of range: write/read addr 0x18 with NUM_REGS=3 → b_resp=10, r_resp=10, r_data=0, and no register changes.
- With NASTILITE_USER_ECHO_EN: aw_user=1 → b_user=1; r_ready held low 4 cycles → r_data/r_valid stable and ar_ready=0 throughout.
